// File: rtl/ldpc_frame_loader.sv
// ldpc_frame_loader
//   Streams one channel frame of intrinsic LLRs into the PE column loading
//   chain. Each accepted LLR is saturated to MESSAGE_WIDTH and written to
//   PE column pe_cnt at RAM address addr_cnt. Columns are filled in order,
//   each one addresses 0..L-1. After a full frame the loader stops
//   accepting input until the decoder swaps frame banks (f_id toggles).
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   in_valid      : input LLR valid
//   in_ready      : loader accepts a beat this cycle
//   in_llr        : signed channel LLR (IN_WIDTH)
//   in_last       : final beat of a frame
//   f_id          : frame-bank id from the PE array
//   load_add      : intrinsic RAM write address (to load_add_in)
//   int_out       : saturated intrinsic message (to int_in)
//   pe_select     : one-hot PE column write strobe
//   frame_loaded  : pulse, frame completed with correct length
//   frame_err     : pulse, frame length error
//   swap_err      : pulse, f_id toggled while a frame was partly loaded
module ldpc_frame_loader #(
    parameter int L             = 32,
    parameter int NUM_PE        = 6,
    parameter int ADDR_WIDTH    = 5,
    parameter int IN_WIDTH      = 8,
    parameter int MESSAGE_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      in_llr,
    input  logic                     in_last,
    input  logic                     f_id,
    output logic [ADDR_WIDTH-1:0]    load_add,
    output logic [MESSAGE_WIDTH-1:0] int_out,
    output logic [NUM_PE-1:0]        pe_select,
    output logic                     frame_loaded,
    output logic                     frame_err,
    output logic                     swap_err
);

    localparam int PE_WIDTH = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
    localparam logic [PE_WIDTH-1:0]   PE_LAST   = PE_WIDTH'(NUM_PE - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
        IN_WIDTH'((1 << (MESSAGE_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
        IN_WIDTH'(-(1 << (MESSAGE_WIDTH - 1)));

    typedef enum logic {
        LOAD,
        WAIT_SWAP
    } state_t;

    state_t                     state, state_next;
    logic [ADDR_WIDTH-1:0]      addr_cnt, addr_next;
    logic [PE_WIDTH-1:0]        pe_cnt, pe_next;
    logic                       f_ref, f_ref_next;
    logic                       f_id_q;
    logic                       loaded_next, err_next, swap_next;
    logic                       accept, final_beat;
    logic signed [IN_WIDTH-1:0] llr_s;
    logic [MESSAGE_WIDTH-1:0]   sat_llr;

    assign in_ready   = (state == LOAD);
    assign accept     = in_valid && in_ready;
    assign final_beat = (pe_cnt == PE_LAST) && (addr_cnt == ADDR_LAST);
    assign llr_s      = in_llr;

    // Clamp to the message range; in-range values keep their low bits,
    // which is exactly the sign-extended value in MESSAGE_WIDTH bits.
    always_comb begin
        sat_llr = llr_s[MESSAGE_WIDTH-1:0];
        if (llr_s > SAT_MAX) begin
            sat_llr = SAT_MAX[MESSAGE_WIDTH-1:0];
        end else if (llr_s < SAT_MIN) begin
            sat_llr = SAT_MIN[MESSAGE_WIDTH-1:0];
        end
    end

    // Next-state, counter stepping and status pulses.
    always_comb begin
        state_next  = state;
        addr_next   = addr_cnt;
        pe_next     = pe_cnt;
        f_ref_next  = f_ref;
        loaded_next = 1'b0;
        err_next    = 1'b0;
        swap_next   = 1'b0;
        case (state)
            LOAD: begin
                // Bank swap while a frame is partly in the RAMs would
                // corrupt it; flag it but keep loading.
                swap_next = (f_id != f_id_q) && ((addr_cnt != '0) || (pe_cnt != '0));
                if (accept) begin
                    if (final_beat) begin
                        state_next  = WAIT_SWAP;
                        addr_next   = '0;
                        pe_next     = '0;
                        f_ref_next  = f_id;
                        loaded_next = in_last;
                        err_next    = !in_last;
                    end else if (in_last) begin
                        addr_next = '0;
                        pe_next   = '0;
                        err_next  = 1'b1;
                    end else if (addr_cnt == ADDR_LAST) begin
                        addr_next = '0;
                        pe_next   = pe_cnt + 1'b1;
                    end else begin
                        addr_next = addr_cnt + 1'b1;
                    end
                end
            end
            WAIT_SWAP: begin
                // Compare the registered f_id so in_ready rises one edge
                // after the toggle is first sampled.
                if (f_id_q != f_ref) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Counters, bank tracking and the registered loading-chain outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt     <= '0;
            pe_cnt       <= '0;
            f_ref        <= 1'b0;
            f_id_q       <= 1'b0;
            load_add     <= '0;
            int_out      <= '0;
            pe_select    <= '0;
            frame_loaded <= 1'b0;
            frame_err    <= 1'b0;
            swap_err     <= 1'b0;
        end else begin
            addr_cnt     <= addr_next;
            pe_cnt       <= pe_next;
            f_ref        <= f_ref_next;
            f_id_q       <= f_id;
            frame_loaded <= loaded_next;
            frame_err    <= err_next;
            swap_err     <= swap_next;
            if (accept) begin
                load_add  <= addr_cnt;
                int_out   <= sat_llr;
                pe_select <= NUM_PE'(1) << pe_cnt;
            end else begin
                pe_select <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_frame_loader.sv
// tb_ldpc_frame_loader
//   Directed self-checking bench for ldpc_frame_loader at default parameters
//   (L=32, NUM_PE=6, 8-bit LLR in, 5-bit message out). Inputs change 1 ns
//   after the rising edge; outputs are sampled at that same point.
module tb_ldpc_frame_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_llr = '0;
    logic       in_last = 1'b0;
    logic       f_id = 1'b0;
    logic [4:0] load_add;
    logic [4:0] int_out;
    logic [5:0] pe_select;
    logic       frame_loaded;
    logic       frame_err;
    logic       swap_err;

    int n_vec  = 0;
    int n_fail = 0;

    ldpc_frame_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_llr      (in_llr),
        .in_last     (in_last),
        .f_id        (f_id),
        .load_add    (load_add),
        .int_out     (int_out),
        .pe_select   (pe_select),
        .frame_loaded(frame_loaded),
        .frame_err   (frame_err),
        .swap_err    (swap_err)
    );

    always #5 clk = ~clk;

    // Present one beat for exactly one edge, then drop valid.
    task automatic send_beat(input logic [7:0] llr, input logic last);
        in_valid = 1'b1;
        in_llr   = llr;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++;
        if ({load_add, int_out, pe_select, frame_loaded, frame_err, swap_err} !== 19'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, want 0",
                     {load_add, int_out, pe_select, frame_loaded, frame_err, swap_err});
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b, want 1", in_ready);
        end
    endtask

    // Full frame, in_llr = beat index mod 16, in_last on beat 191.
    task automatic test_full_frame();
        logic [5:0] exp_pe;
        for (int i = 0; i < 192; i++) begin
            send_beat(8'(i % 16), i == 191);
            exp_pe = 6'(1 << (i / 32));
            n_vec++;
            if (pe_select !== exp_pe || load_add !== 5'(i % 32) || int_out !== 5'(i % 16)) begin
                n_fail++;
                $display("[TB] FAIL full_beat %0d: pe=%b addr=%0d int=%0d, want pe=%b addr=%0d int=%0d",
                         i, pe_select, load_add, int_out, exp_pe, i % 32, i % 16);
            end
            n_vec++;
            if (frame_loaded !== (i == 191) || frame_err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL full_flags %0d: loaded=%b err=%b, want loaded=%b err=0",
                         i, frame_loaded, frame_err, i == 191);
            end
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_ready_low: got %b, want 0", in_ready);
        end
    endtask

    // Hold valid while waiting for a swap, then toggle f_id and watch
    // in_ready rise two edges later.
    task automatic test_bank_swap(input int hold, input logic [4:0] last_addr);
        in_valid = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (pe_select !== 6'd0 || in_ready !== 1'b0 || load_add !== last_addr) begin
                n_fail++;
                $display("[TB] FAIL swap_hold %0d: pe=%b ready=%b addr=%0d, want pe=0 ready=0 addr=%0d",
                         c, pe_select, in_ready, load_add, last_addr);
            end
        end
        in_valid = 1'b0;
        f_id = ~f_id;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL swap_ready_edge1: got %b, want 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL swap_ready_edge2: got %b, want 1", in_ready);
        end
    endtask

    // Starts frame 2: first beat must land on PE 0 address 0.
    task automatic test_saturation();
        logic [7:0] vin  [5] = '{8'd100, 8'h9C, 8'd15, 8'hF0, 8'hEF};
        logic [4:0] vexp [5] = '{5'd15, 5'h10, 5'd15, 5'h10, 5'h10};
        for (int i = 0; i < 5; i++) begin
            send_beat(vin[i], 1'b0);
            n_vec++;
            if (int_out !== vexp[i] || load_add !== 5'(i) || pe_select !== 6'b000001) begin
                n_fail++;
                $display("[TB] FAIL sat %0d: int=%h addr=%0d pe=%b, want int=%h addr=%0d pe=000001",
                         i, int_out, load_add, pe_select, vexp[i], i);
            end
        end
    endtask

    // Continues frame 2 from beat 5; in_last on beat 40 is a short frame.
    task automatic test_short_frame();
        for (int i = 5; i <= 40; i++) begin
            send_beat(8'd3, i == 40);
            n_vec++;
            if (frame_err !== (i == 40) || frame_loaded !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL short_flags %0d: err=%b loaded=%b, want err=%b loaded=0",
                         i, frame_err, frame_loaded, i == 40);
            end
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL short_stays_load: ready=%b, want 1", in_ready);
        end
        send_beat(8'd1, 1'b0);
        n_vec++;
        if (pe_select !== 6'b000001 || load_add !== 5'd0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL short_restart: pe=%b addr=%0d err=%b, want pe=000001 addr=0 err=0",
                     pe_select, load_add, frame_err);
        end
    endtask

    // Beat 0 was sent by test_short_frame; beats 1..191 without in_last.
    task automatic test_missing_last();
        for (int i = 1; i < 192; i++) begin
            send_beat(8'd2, 1'b0);
        end
        n_vec++;
        if (frame_err !== 1'b1 || frame_loaded !== 1'b0 || pe_select !== 6'b100000 || load_add !== 5'd31) begin
            n_fail++;
            $display("[TB] FAIL missing_last: err=%b loaded=%b pe=%b addr=%0d, want err=1 loaded=0 pe=100000 addr=31",
                     frame_err, frame_loaded, pe_select, load_add);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL missing_last_wait: ready=%b, want 0", in_ready);
        end
    endtask

    // Random gaps with in_last held high while invalid (must be ignored).
    task automatic test_valid_gaps();
        int strobes = 0;
        int gap;
        for (int i = 0; i < 192; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_last = 1'b1;
                @(posedge clk);
                #1;
                in_last = 1'b0;
                if (pe_select != 6'd0) strobes++;
                n_vec++;
                if (pe_select !== 6'd0 || frame_err !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL gap_idle %0d: pe=%b err=%b, want pe=0 err=0",
                             i, pe_select, frame_err);
                end
            end
            send_beat(8'(i % 16), i == 191);
            if (pe_select != 6'd0) strobes++;
            n_vec++;
            if (pe_select !== 6'(1 << (i / 32)) || load_add !== 5'(i % 32)) begin
                n_fail++;
                $display("[TB] FAIL gap_beat %0d: pe=%b addr=%0d, want pe=%b addr=%0d",
                         i, pe_select, load_add, 6'(1 << (i / 32)), i % 32);
            end
        end
        n_vec++;
        if (strobes != 192 || frame_loaded !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gap_total: strobes=%0d loaded=%b, want strobes=192 loaded=1",
                     strobes, frame_loaded);
        end
    endtask

    // f_id toggles just before beat 100 is accepted.
    task automatic test_swap_err();
        int pulses = 0;
        for (int i = 0; i < 192; i++) begin
            if (i == 100) f_id = ~f_id;
            send_beat(8'd5, i == 191);
            if (swap_err === 1'b1) pulses++;
            n_vec++;
            if (swap_err !== (i == 100)) begin
                n_fail++;
                $display("[TB] FAIL swap_err_beat %0d: got %b, want %b", i, swap_err, i == 100);
            end
        end
        n_vec++;
        if (pulses != 1 || frame_loaded !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL swap_err_frame: pulses=%0d loaded=%b ready=%b, want 1 1 0",
                     pulses, frame_loaded, in_ready);
        end
    endtask

    // Reset lands on the edge that would accept beat 50.
    task automatic test_reset_mid();
        for (int i = 0; i < 50; i++) begin
            send_beat(8'd7, 1'b0);
        end
        reset    = 1'b1;
        in_valid = 1'b1;
        in_llr   = 8'd9;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_vec++;
        if ({load_add, int_out, pe_select, frame_loaded, frame_err, swap_err} !== 19'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: outs=%h ready=%b, want 0 and ready=1",
                     {load_add, int_out, pe_select, frame_loaded, frame_err, swap_err}, in_ready);
        end
        send_beat(8'd4, 1'b0);
        n_vec++;
        if (pe_select !== 6'b000001 || load_add !== 5'd0 || int_out !== 5'd4) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_restart: pe=%b addr=%0d int=%0d, want 000001 0 4",
                     pe_select, load_add, int_out);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_bank_swap(20, 5'd31);
        test_saturation();
        test_short_frame();
        test_missing_last();
        test_bank_swap(3, 5'd31);
        test_valid_gaps();
        test_bank_swap(2, 5'd31);
        test_swap_err();
        test_bank_swap(2, 5'd31);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
